// File: rtl/md_ctrl_if.sv
// md_ctrl_if: command/result bundle between the E stage, the hazard unit and
// the HI/LO multiply/divide sequencer.
//
// Handshake: a command is taken on a rising edge when start is high, flush is
// low, busy is low and op is a legal code for the build; there is no ready
// signal, so the D stage is held off with stall_md instead of back-pressure.
interface md_ctrl_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush, md_use_D,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, md_use_D,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO multiply/divide sequencer. Computes the result at accept,
// holds it in pending registers for the modelled latency, then commits it to
// HI/LO. Optional multiply-accumulate ops (6..9) are enabled by defining
// MD_MADD_EN; without it those codes are treated as illegal.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_ctrl_if.slave   bus,
    output logic       dbg_state
);
    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] hi_q, lo_q, phi, plo;

    logic        legal, is_long, busy, acc;
    logic [4:0]  load_cnt;
    logic [63:0] hl, prod_s, prod_u, res;
    logic [31:0] a_mag, b_mag, den_s, den_u;
    logic [31:0] qm, rm, q_s, r_s, q_u, r_u;

    assign hl     = {hi_q, lo_q};
    assign prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_mag = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    assign b_mag = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
    assign den_s = (bus.b == 32'd0) ? 32'd1 : b_mag;
    assign den_u = (bus.b == 32'd0) ? 32'd1 : bus.b;
    assign qm    = a_mag / den_s;
    assign rm    = a_mag % den_s;
    assign q_s   = (bus.a[31] ^ bus.b[31]) ? (~qm + 32'd1) : qm;
    assign r_s   = bus.a[31] ? (~rm + 32'd1) : rm;
    assign q_u   = bus.a / den_u;
    assign r_u   = bus.a % den_u;

    // Opcode decode and the {hi,lo} value the command would produce.
    always_comb begin
        legal    = 1'b0;
        is_long  = 1'b0;
        load_cnt = 5'd0;
        res      = hl;
        case (bus.op)
            OP_MULT:  begin legal = 1'b1; is_long = 1'b1; load_cnt = 5'(MULT_CYCLES); res = prod_s; end
            OP_MULTU: begin legal = 1'b1; is_long = 1'b1; load_cnt = 5'(MULT_CYCLES); res = prod_u; end
            OP_DIV: begin
                legal = 1'b1; is_long = 1'b1; load_cnt = 5'(DIV_CYCLES);
                res = (bus.b == 32'd0) ? hl : {r_s, q_s};
            end
            OP_DIVU: begin
                legal = 1'b1; is_long = 1'b1; load_cnt = 5'(DIV_CYCLES);
                res = (bus.b == 32'd0) ? hl : {r_u, q_u};
            end
            OP_MTHI:  begin legal = 1'b1; res = {bus.a, lo_q}; end
            OP_MTLO:  begin legal = 1'b1; res = {hi_q, bus.a}; end
`ifdef MD_MADD_EN
            OP_MADD:  begin legal = 1'b1; is_long = 1'b1; load_cnt = 5'(MULT_CYCLES); res = hl + prod_s; end
            OP_MADDU: begin legal = 1'b1; is_long = 1'b1; load_cnt = 5'(MULT_CYCLES); res = hl + prod_u; end
            OP_MSUB:  begin legal = 1'b1; is_long = 1'b1; load_cnt = 5'(MULT_CYCLES); res = hl - prod_s; end
            OP_MSUBU: begin legal = 1'b1; is_long = 1'b1; load_cnt = 5'(MULT_CYCLES); res = hl - prod_u; end
`else
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
    end

    assign busy         = (state == RUN);
    assign acc          = bus.start & ~bus.flush & ~busy & legal;
    assign bus.busy     = busy;
    assign bus.stall_md = bus.md_use_D & (busy | acc);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign dbg_state    = state;

    // Sequencer: latch pending result on accept, count down, commit at cnt==1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            phi   <= 32'd0;
            plo   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (is_long) begin
                            phi   <= res[63:32];
                            plo   <= res[31:0];
                            cnt   <= load_cnt;
                            state <= RUN;
                        end else begin
                            hi_q <= res[63:32];
                            lo_q <= res[31:0];
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        hi_q  <= phi;
                        lo_q  <= plo;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
